// File: rtl/mem_access_if.sv
// mem_access_if: MEM-stage request/response bus plus the data memory port of the load/store unit
interface mem_access_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dm_we;
    logic [1:0]  dm_store_type;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        misalign_fault;
    modport master (
        output mem_read, mem_write, funct3, addr, store_data, dm_rd,
        input  dm_we, dm_store_type, dm_addr, dm_wd, load_data, load_valid, stall, misalign_fault
    );
    modport slave (
        input  mem_read, mem_write, funct3, addr, store_data, dm_rd,
        output dm_we, dm_store_type, dm_addr, dm_wd, load_data, load_valid, stall, misalign_fault
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I MEM-stage load/store unit that splits misaligned accesses into serial steps
module mem_access_unit #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] lo_q, lo_d;
    logic        st_req, ld_req, st_mis, ld_mis, last_byte;
    function automatic logic [31:0] ext(input logic [31:0] v, input logic [2:0] f);
        return f[1]            ? v :
               f[0] && !f[2]   ? {{16{v[15]}}, v[15:0]} :
               f[0]            ? {16'h0, v[15:0]} :
               !f[2]           ? {{24{v[7]}}, v[7:0]} :
                                 {24'h0, v[7:0]};
    endfunction
    assign st_req    = bus.mem_write && (bus.funct3 inside {3'b000, 3'b001, 3'b010});
    assign ld_req    = bus.mem_read && !bus.mem_write && (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign st_mis    = (bus.funct3 == 3'b001 && bus.addr[0]) || (bus.funct3 == 3'b010 && bus.addr[1:0] != 2'b00);
    assign ld_mis    = (bus.funct3[1:0] == 2'b01 && bus.addr[1:0] == 2'b11) || (bus.funct3 == 3'b010 && bus.addr[1:0] != 2'b00);
    assign last_byte = byte_cnt_q == (bus.funct3[1] ? 2'd3 : 2'd1);
    // State, split-store byte counter and low word of a word-crossing load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            lo_q       <= 32'h0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            lo_q       <= lo_d;
        end
    end
    // Next state and memory/pipeline outputs; everything is quiet while in reset
    always_comb begin
        state_d            = state_q;
        byte_cnt_d         = byte_cnt_q;
        lo_d               = lo_q;
        bus.dm_we          = 1'b0;
        bus.dm_store_type  = 2'b00;
        bus.dm_addr        = 32'h0;
        bus.dm_wd          = 32'h0;
        bus.load_data      = 32'h0;
        bus.load_valid     = 1'b0;
        bus.stall          = 1'b0;
        bus.misalign_fault = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (st_req && st_mis && !MISALIGN_EN) begin
                        bus.misalign_fault = 1'b1;
                    end else if (st_req && st_mis) begin
                        bus.dm_we         = 1'b1;
                        bus.dm_store_type = 2'b01;
                        bus.dm_addr       = bus.addr;
                        bus.dm_wd         = {24'h0, bus.store_data[7:0]};
                        bus.stall         = 1'b1;
                        byte_cnt_d        = 2'd1;
                        state_d           = ST_BYTE;
                    end else if (st_req) begin
                        bus.dm_we         = 1'b1;
                        bus.dm_store_type = bus.funct3[1:0] + 2'd1;
                        bus.dm_addr       = bus.addr;
                        bus.dm_wd         = bus.store_data;
                    end else if (ld_req && ld_mis && !MISALIGN_EN) begin
                        bus.misalign_fault = 1'b1;
                    end else if (ld_req && ld_mis) begin
                        bus.dm_addr = {bus.addr[31:2], 2'b00};
                        bus.stall   = 1'b1;
                        lo_d        = bus.dm_rd;
                        state_d     = LD_HI;
                    end else if (ld_req) begin
                        bus.dm_addr    = bus.addr;
                        bus.load_data  = ext(bus.dm_rd >> {bus.addr[1:0], 3'b000}, bus.funct3);
                        bus.load_valid = 1'b1;
                    end
                end
                LD_HI: begin
                    bus.dm_addr    = {bus.addr[31:2], 2'b00} + 32'd4;
                    bus.load_data  = ext(32'({bus.dm_rd, lo_q} >> {bus.addr[1:0], 3'b000}), bus.funct3);
                    bus.load_valid = 1'b1;
                    state_d        = IDLE;
                end
                ST_BYTE: begin
                    bus.dm_we         = 1'b1;
                    bus.dm_store_type = 2'b01;
                    bus.dm_addr       = bus.addr + 32'(byte_cnt_q);
                    bus.dm_wd         = {24'h0, 8'(bus.store_data >> {byte_cnt_q, 3'b000})};
                    bus.stall         = !last_byte;
                    byte_cnt_d        = last_byte ? 2'd0 : byte_cnt_q + 2'd1;
                    state_d           = last_byte ? IDLE : ST_BYTE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule
